pixel_rgb_quantizer: RTL and testbench
======================================

Name: pixel_rgb_quantizer

Overview:
- Parametrised float-to-integer colour formatter at the tail of the ray-trace shading path, between the per-pixel shading pipeline and the frame-buffer writer.
- Takes NCH float32 channels plus pixel XY; clamps each channel to [0,1] and scales by 2^OUT_W-1; rounds half-up or with 4x4 ordered dither.
- Emits OUT_W-bit integers with XY carried in-pipe: no external delay line, no float IP.
- Adds valid/ready backpressure, which the previous fixed-latency formatter lacked.

Parameters:
- NCH, 3, number of colour channels.
- OUT_W, 4, output bits per channel (legal 1..12).
- FB, OUT_W+8, fraction bits of the internal fixed-point value.
- X_W, 11, pixel x width.
- Y_W, 10, pixel y width.

Ports:
- clk_in  in  1  clock.
- rst_in_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts the input this cycle.
- in_ch  in  NCH*32  IEEE-754 single per channel; channel 0 in the LSBs.
- in_x  in  X_W  pixel x.
- in_y  in  Y_W  pixel y.
- in_dither  in  1  per-pixel select: 1 = ordered dither, 0 = round half-up.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts.
- out_ch  out  NCH*OUT_W  quantised channels; channel 0 in the LSBs.
- out_x  out  X_W  x of the output pixel.
- out_y  out  Y_W  y of the output pixel.

Behaviour:
- Reset: asynchronous assertion clears all stage valids, out_valid, out_ch, out_x and out_y to 0. in_ready is 1 after reset.
- Reset mid-stream drops every in-flight pixel; there is no partial output.
- Pipeline: 4 register stages S1..S4, with S4 being the output register.
- Latency: exactly 4 cycles from the accept edge to out_valid when not stalled. Throughput is 1 pixel/clk.
- Advance enable: en = !out_valid | out_ready. All stages advance together when en=1.
- in_ready = en, combinational. Transfer occurs when in_valid & in_ready.
- When en=0, every stage holds; out_* are stable while out_valid=1 and out_ready=0.
- Pixels are never dropped, duplicated or reordered.
- x, y and in_dither travel with the pixel through every stage.
- S1 (classify), per channel, with s = sign, e = exponent, m = mantissa:
  - NaN → ZERO.
  - s=1 (including -0) → ZERO.
  - e=0 (zero or denormal) → ZERO.
  - +inf or e≥127 (v≥1.0) → SAT.
  - Otherwise → NORM; register m and sh = 150-e.
- S2 (align): F = ({1,m} << FB) >> sh, truncated. F = 0 when sh > FB+24.
- S3 (scale and round):
  - P = (F << OUT_W) - F, computed at FB+OUT_W+1 bits.
  - Round constant R = 2^(FB-1) when dither=0.
  - R = (2B+1) << (FB-5) when dither=1, where B = Bayer[y[1:0]][x[1:0]].
  - Bayer rows: {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.
  - q = (P+R) >> FB, saturated to 2^OUT_W-1.
- ZERO → q=0; SAT → q=2^OUT_W-1, with no rounding or dither applied.
- This algorithm is bit-exact; the scoreboard model implements it literally.
- Simultaneous accept and output handshake in the same cycle is the normal full-rate case.

Decomposition:
- Package pixel_quant_pkg holds:
  - the chan_class_t enum {ZERO, SAT, NORM};
  - the BAYER4 constant array;
  - float field-width localparams.
- One sub-module, float_unit_quantize: per-channel S1..S3 datapath with an enable input, instantiated NCH times.
- The top module holds the valid/XY/dither pipeline and the handshake.

Test Plan:
- OUT_W=8, dither=0, channels {0x3F800000, 0x3F000000, 0x00000000} → out_ch {255, 128, 0}; out_valid exactly 4 cycles after accept.
- OUT_W=8, inputs {0xBE99999A (-0.3), 0x7FC00000 (NaN), 0x7F800000 (+inf)} → {0, 0, 255}; 2.0 (0x40000000) → 255.
- OUT_W=4, dither=1, 0.5 at (x,y)=(0,0) → 8 and at (3,3) → 7; dither=0 at (3,3) → 8.
- Continuous 20-pixel stream with out_ready low on cycles 6-8 → in_ready low on the same cycles; all 20 outputs arrive in order with matching XY; out_* held stable while stalled.
- rst_in_n pulsed low asynchronously, mid-clock, with 3 pixels in flight → out_valid drops immediately and none of the 3 emerge; the next pixel after release returns after 4 cycles.
- Random 10k pixels (including denormals, negatives and values near 1.0) against the bit-exact model, for OUT_W ∈ {1, 4, 8, 12} → zero mismatches.

Source files
------------

// File: rtl/pixel_quant_pkg.sv
// Shared types and constants for the float-to-integer pixel quantiser.
// Channel classes, IEEE-754 single field widths and the 4x4 ordered-dither matrix.
package pixel_quant_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 23;
  localparam int unsigned EXP_BIAS = 127;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    SAT  = 2'd1,
    NORM = 2'd2
  } chan_class_t;

  // Indexed [y[1:0]][x[1:0]].
  localparam logic [3:0] BAYER4 [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6},
    '{4'd3,  4'd11, 4'd1,  4'd9},
    '{4'd15, 4'd7,  4'd13, 4'd5}
  };

endpackage

// File: rtl/float_unit_quantize.sv
// One colour channel: classify (S1), align to fixed point (S2), scale and round (S3).
// Dither select and pixel XY for the S3 round come from the top's S2 pipeline slot.
module float_unit_quantize
  import pixel_quant_pkg::*;
#(
  parameter int unsigned OUT_W = 4,
  parameter int unsigned FB    = OUT_W + 8
) (
  input  logic             clk_in,
  input  logic             rst_in_n,
  input  logic             en,
  input  logic [FP_W-1:0]  in_f,
  input  logic             s2_dither,
  input  logic [1:0]       s2_x,
  input  logic [1:0]       s2_y,
  output logic [OUT_W-1:0] q
);

  localparam int unsigned AW = FB + MAN_W + 1;
  localparam int unsigned SW = FB + OUT_W + 2;
  localparam int unsigned QW = OUT_W + 2;
  localparam logic [OUT_W-1:0] QMAX = '1;

  logic             sgn;
  logic [EXP_W-1:0] expo;
  logic [MAN_W-1:0] man;
  assign {sgn, expo, man} = in_f;

  chan_class_t      cls1_d, cls1_q, cls2_q;
  logic [MAN_W-1:0] man1_q;
  logic [EXP_W-1:0] sh1_d, sh1_q;
  logic [AW-1:0]    aligned;
  logic [FB-1:0]    f2_d, f2_q;
  logic [SW-1:0]    f_ext, prod, rnd, sum;
  logic [QW-1:0]    q_wide;
  logic [3:0]       bayer;
  logic [OUT_W-1:0] q_d;

  always_comb begin
    cls1_d = NORM;
    if (expo == '1 && man != '0) begin
      cls1_d = ZERO;
    end else if (sgn) begin
      cls1_d = ZERO;
    end else if (expo == '0) begin
      cls1_d = ZERO;
    end else if (expo >= EXP_W'(EXP_BIAS)) begin
      cls1_d = SAT;
    end
  end

  assign sh1_d = EXP_W'(EXP_BIAS + MAN_W) - expo;

  assign aligned = {1'b1, man1_q, {FB{1'b0}}} >> sh1_q;
  // A NORM value is below 1.0, so the integer part is zero; clamp defensively if not.
  assign f2_d = (|aligned[AW-1:FB]) ? '1 : aligned[FB-1:0];

  assign bayer = BAYER4[s2_y][s2_x];

  always_comb begin
    f_ext  = SW'(f2_q);
    prod   = (f_ext << OUT_W) - f_ext;
    rnd    = s2_dither ? (SW'({bayer, 1'b1}) << (FB - 5)) : (SW'(1) << (FB - 1));
    sum    = prod + rnd;
    q_wide = sum[SW-1:FB];
    case (cls2_q)
      ZERO:    q_d = '0;
      SAT:     q_d = QMAX;
      default: q_d = (q_wide > QW'(QMAX)) ? QMAX : q_wide[OUT_W-1:0];
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      cls1_q <= ZERO;
      man1_q <= '0;
      sh1_q  <= '0;
      cls2_q <= ZERO;
      f2_q   <= '0;
      q      <= '0;
    end else if (en) begin
      cls1_q <= cls1_d;
      man1_q <= man;
      sh1_q  <= sh1_d;
      cls2_q <= cls1_q;
      f2_q   <= f2_d;
      q      <= q_d;
    end
  end

endmodule

// File: rtl/pixel_rgb_quantizer.sv
// Float32 colour to OUT_W-bit integer formatter with valid/ready backpressure.
// Four lock-step stages; XY and dither select ride alongside the channel datapaths.
module pixel_rgb_quantizer
  import pixel_quant_pkg::*;
#(
  parameter int unsigned NCH   = 3,
  parameter int unsigned OUT_W = 4,
  parameter int unsigned FB    = OUT_W + 8,
  parameter int unsigned X_W   = 11,
  parameter int unsigned Y_W   = 10
) (
  input  logic                 clk_in,
  input  logic                 rst_in_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*FP_W-1:0]  in_ch,
  input  logic [X_W-1:0]       in_x,
  input  logic [Y_W-1:0]       in_y,
  input  logic                 in_dither,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*OUT_W-1:0] out_ch,
  output logic [X_W-1:0]       out_x,
  output logic [Y_W-1:0]       out_y
);

  logic                 en;
  logic [2:0]           vld_q;
  logic [X_W-1:0]       x_q [3];
  logic [Y_W-1:0]       y_q [3];
  logic [2:0]           dith_q;
  logic [NCH*OUT_W-1:0] q_all;

  // The whole pipe stalls only when the output register is full and not being taken.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    float_unit_quantize #(
      .OUT_W (OUT_W),
      .FB    (FB)
    ) u_quant (
      .clk_in    (clk_in),
      .rst_in_n  (rst_in_n),
      .en        (en),
      .in_f      (in_ch[ch*FP_W +: FP_W]),
      .s2_dither (dith_q[1]),
      .s2_x      (x_q[1][1:0]),
      .s2_y      (y_q[1][1:0]),
      .q         (q_all[ch*OUT_W +: OUT_W])
    );
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      vld_q     <= '0;
      dith_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (en) begin
      vld_q     <= {vld_q[1:0], in_valid};
      dith_q    <= {dith_q[1:0], in_dither};
      x_q[0]    <= in_x;
      y_q[0]    <= in_y;
      for (int i = 1; i < 3; i++) begin
        x_q[i] <= x_q[i-1];
        y_q[i] <= y_q[i-1];
      end
      out_valid <= vld_q[2];
      out_ch    <= q_all;
      out_x     <= x_q[2];
      out_y     <= y_q[2];
    end
  end

endmodule

// File: tb/tb_pixel_rgb_quantizer.sv
// Self-checking bench: four quantisers (OUT_W = 1, 4, 8, 12) share one stimulus stream
// and are compared each cycle against an arithmetic model of the quantisation rules.
module tb_pixel_rgb_quantizer;

  logic        clk_in = 1'b0;
  logic        rst_in_n;
  logic        in_valid, in_dither, out_ready;
  logic [95:0] in_ch;
  logic [10:0] in_x;
  logic [9:0]  in_y;

  logic        ir1, ir4, ir8, ir12, ov1, ov4, ov8, ov12;
  logic [2:0]  oc1;
  logic [11:0] oc4;
  logic [23:0] oc8;
  logic [35:0] oc12;
  logic [10:0] ox1, ox4, ox8, ox12;
  logic [9:0]  oy1, oy4, oy8, oy12;

  always #5 clk_in = ~clk_in;

  pixel_rgb_quantizer #(.OUT_W(1)) u_w1 (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .in_valid(in_valid), .in_ready(ir1), .in_ch(in_ch),
    .in_x(in_x), .in_y(in_y), .in_dither(in_dither), .out_valid(ov1), .out_ready(out_ready),
    .out_ch(oc1), .out_x(ox1), .out_y(oy1));
  pixel_rgb_quantizer #(.OUT_W(4)) u_w4 (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .in_valid(in_valid), .in_ready(ir4), .in_ch(in_ch),
    .in_x(in_x), .in_y(in_y), .in_dither(in_dither), .out_valid(ov4), .out_ready(out_ready),
    .out_ch(oc4), .out_x(ox4), .out_y(oy4));
  pixel_rgb_quantizer #(.OUT_W(8)) u_w8 (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .in_valid(in_valid), .in_ready(ir8), .in_ch(in_ch),
    .in_x(in_x), .in_y(in_y), .in_dither(in_dither), .out_valid(ov8), .out_ready(out_ready),
    .out_ch(oc8), .out_x(ox8), .out_y(oy8));
  pixel_rgb_quantizer #(.OUT_W(12)) u_w12 (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .in_valid(in_valid), .in_ready(ir12), .in_ch(in_ch),
    .in_x(in_x), .in_y(in_y), .in_dither(in_dither), .out_valid(ov12), .out_ready(out_ready),
    .out_ch(oc12), .out_x(ox12), .out_y(oy12));

  typedef struct {
    bit          v;
    logic [10:0] x;
    logic [9:0]  y;
    logic [2:0]  e1;
    logic [11:0] e4;
    logic [23:0] e8;
    logic [35:0] e12;
  } slot_t;

  slot_t       m [4];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          acc, pop;
  int          lat, sent, pops;
  logic [23:0] cap8;
  logic [11:0] cap4;
  logic [10:0] capx;
  int          bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
  logic [31:0] specials [6] = '{32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h80000000,
                                32'h00000000, 32'h3F800000};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Value-level quantisation: v clamped to [0,1], times 2^ow-1, plus rounding offset, floored.
  function automatic longint quant(input logic [31:0] f, input int ow, input bit d,
                                   input int x, input int y);
    int     e, sh, fb;
    longint mant, fx, p, r, q, maxq;
    e    = int'(f[30:23]);
    mant = longint'({1'b1, f[22:0]});
    maxq = (longint'(1) << ow) - 1;
    fb   = ow + 8;
    if (e == 255 && f[22:0] != 23'd0) return 0;
    if (f[31]) return 0;
    if (e == 0) return 0;
    if (e >= 127) return maxq;
    sh = 150 - e;
    fx = (sh > fb + 24) ? 0 : ((mant << fb) >> sh);
    p  = fx * maxq;
    r  = d ? (longint'(2 * bayer[y & 3][x & 3] + 1) << (fb - 5)) : (longint'(1) << (fb - 1));
    q  = (p + r) >> fb;
    if (q > maxq) q = maxq;
    return q;
  endfunction

  function automatic slot_t mk();
    slot_t  s;
    longint t;
    logic [31:0] f;
    s.v = 1'b1;
    s.x = in_x;
    s.y = in_y;
    for (int c = 0; c < 3; c++) begin
      f = in_ch[c*32 +: 32];
      t = quant(f, 1, in_dither, int'(in_x), int'(in_y));
      s.e1[c +: 1] = t[0:0];
      t = quant(f, 4, in_dither, int'(in_x), int'(in_y));
      s.e4[c*4 +: 4] = t[3:0];
      t = quant(f, 8, in_dither, int'(in_x), int'(in_y));
      s.e8[c*8 +: 8] = t[7:0];
      t = quant(f, 12, in_dither, int'(in_x), int'(in_y));
      s.e12[c*12 +: 12] = t[11:0];
    end
    return s;
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [31:0] r, res;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       res = r;
      1:       res = {1'b0, 8'd0, r[22:0]};
      2:       res = {1'b1, r[30:0]};
      3:       res = {1'b0, 8'd126, 15'h7FFF, r[7:0]};
      4:       res = specials[$urandom_range(0, 5)];
      5:       res = {1'b0, 8'($urandom_range(90, 127)), r[22:0]};
      default: res = {1'b0, 8'($urandom_range(100, 126)), r[22:0]};
    endcase
    return res;
  endfunction

  // Called just before an active edge: compare outputs, then advance the model pipe.
  task automatic sample_model();
    bit en_m;
    acc = 1'b0;
    pop = 1'b0;
    if (!rst_in_n) begin
      for (int i = 0; i < 4; i++) m[i].v = 1'b0;
    end else begin
      en_m = !m[3].v || out_ready;
      check("in_ready_w1", 64'(ir1), 64'(en_m));
      check("in_ready_w4", 64'(ir4), 64'(en_m));
      check("in_ready_w8", 64'(ir8), 64'(en_m));
      check("in_ready_w12", 64'(ir12), 64'(en_m));
      check("out_valid_w1", 64'(ov1), 64'(m[3].v));
      check("out_valid_w4", 64'(ov4), 64'(m[3].v));
      check("out_valid_w8", 64'(ov8), 64'(m[3].v));
      check("out_valid_w12", 64'(ov12), 64'(m[3].v));
      if (m[3].v) begin
        check("out_ch_w1", 64'(oc1), 64'(m[3].e1));
        check("out_ch_w4", 64'(oc4), 64'(m[3].e4));
        check("out_ch_w8", 64'(oc8), 64'(m[3].e8));
        check("out_ch_w12", 64'(oc12), 64'(m[3].e12));
        check("out_x_w1", 64'(ox1), 64'(m[3].x));
        check("out_x_w4", 64'(ox4), 64'(m[3].x));
        check("out_x_w8", 64'(ox8), 64'(m[3].x));
        check("out_x_w12", 64'(ox12), 64'(m[3].x));
        check("out_y_w1", 64'(oy1), 64'(m[3].y));
        check("out_y_w4", 64'(oy4), 64'(m[3].y));
        check("out_y_w8", 64'(oy8), 64'(m[3].y));
        check("out_y_w12", 64'(oy12), 64'(m[3].y));
      end
      pop = m[3].v && out_ready;
      if (en_m) begin
        m[3] = m[2];
        m[2] = m[1];
        m[1] = m[0];
        if (in_valid) m[0] = mk();
        else m[0].v = 1'b0;
        acc = in_valid;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    sample_model();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_one(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2,
                          input int x, input int y, input bit d);
    in_ch     = {c2, c1, c0};
    in_x      = 11'(x);
    in_y      = 10'(y);
    in_dither = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      if (lat < 0 && ov8) begin
        lat  = k;
        cap8 = oc8;
        cap4 = oc4;
        capx = ox8;
      end
      sample_model();
      @(posedge clk_in);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m[i].v = 1'b0;
    rst_in_n  = 1'b0;
    in_valid  = 1'b0;
    in_dither = 1'b0;
    in_ch     = '0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b1;
    #3;
    check("reset_out_valid_w8", 64'(ov8), 64'(0));
    check("reset_out_valid_w1", 64'(ov1), 64'(0));
    check("reset_in_ready_w8", 64'(ir8), 64'(1));
    check("reset_out_ch_w8", 64'(oc8), 64'(0));
    check("reset_out_ch_w12", 64'(oc12), 64'(0));
    check("reset_out_x", 64'(ox8), 64'(0));
    check("reset_out_y", 64'(oy8), 64'(0));
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in_n = 1'b1;
    tick();
    tick();

    send_one(32'h3F800000, 32'h3F000000, 32'h00000000, 5, 7, 1'b0);
    check("basic_latency", 64'(lat), 64'(4));
    check("basic_ch_w8", 64'(cap8), 64'({8'd0, 8'd128, 8'd255}));
    check("basic_x", 64'(capx), 64'(5));
    send_one(32'hBE99999A, 32'h7FC00000, 32'h7F800000, 9, 2, 1'b0);
    check("special_ch_w8", 64'(cap8), 64'({8'd255, 8'd0, 8'd0}));
    send_one(32'h40000000, 32'h00000000, 32'h00000000, 1, 1, 1'b0);
    check("two_ch_w8", 64'(cap8), 64'({8'd0, 8'd0, 8'd255}));

    // 0.5 at OUT_W=4 sits at 7.5; dither offset (2B+1)/32 crosses 8 only for B >= 8.
    send_one(32'h3F000000, 32'h3F000000, 32'h3F000000, 0, 0, 1'b1);
    check("dither_00_w4", 64'(cap4), 64'(12'h777));
    send_one(32'h3F000000, 32'h3F000000, 32'h3F000000, 1, 0, 1'b1);
    check("dither_10_w4", 64'(cap4), 64'(12'h888));
    send_one(32'h3F000000, 32'h3F000000, 32'h3F000000, 3, 3, 1'b1);
    check("dither_33_w4", 64'(cap4), 64'(12'h777));
    send_one(32'h3F000000, 32'h3F000000, 32'h3F000000, 3, 3, 1'b0);
    check("round_33_w4", 64'(cap4), 64'(12'h888));

    // 20-pixel stream with a three-cycle downstream stall.
    sent = 0;
    pops = 0;
    for (int cyc = 0; cyc < 80 && pops < 20; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (sent < 20);
      in_x      = 11'(sent);
      in_y      = 10'(100 + sent);
      in_dither = 1'(sent & 1);
      in_ch     = {rnd_f(), rnd_f(), rnd_f()};
      @(negedge clk_in);
      check("stream_in_ready", 64'(ir8), 64'(!(cyc >= 6 && cyc <= 8)));
      if (ov8 && out_ready) begin
        check("stream_order_x", 64'(ox8), 64'(pops));
        pops++;
      end
      sample_model();
      if (acc) sent++;
      @(posedge clk_in);
      #1;
    end
    in_valid = 1'b0;
    check("stream_count", 64'(pops), 64'(20));

    // Asynchronous reset with one pixel at the output and three behind it.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_ch = {rnd_f(), rnd_f(), rnd_f()};
      in_x  = 11'(200 + k);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    check("rst_pre_out_valid", 64'(ov8), 64'(1));
    rst_in_n = 1'b0;
    #1;
    check("rst_out_valid_w1", 64'(ov1), 64'(0));
    check("rst_out_valid_w4", 64'(ov4), 64'(0));
    check("rst_out_valid_w8", 64'(ov8), 64'(0));
    check("rst_out_valid_w12", 64'(ov12), 64'(0));
    check("rst_in_ready", 64'(ir8), 64'(1));
    tick();
    tick();
    #2;
    rst_in_n  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    send_one(32'h3F400000, 32'h3E800000, 32'h3F7FFFFF, 77, 33, 1'b0);
    check("post_rst_latency", 64'(lat), 64'(4));
    check("post_rst_x", 64'(capx), 64'(77));

    // Random traffic with random backpressure.
    sent = 0;
    for (int cyc = 0; cyc < 40000 && sent < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      in_ch     = {rnd_f(), rnd_f(), rnd_f()};
      in_x      = 11'($urandom);
      in_y      = 10'($urandom);
      in_dither = 1'($urandom_range(0, 1));
      tick();
      if (acc) sent++;
    end
    check("random_accepted", 64'(sent), 64'(10000));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
